fft_mult_arb: RTL and testbench

Two-requester round-robin arbiter that shares one `fft_mult_comp` complex multiplier between two FFT butterfly engines (port A, port B). Operands are accepted with a valid/ready handshake, registered into the multiplier, and carried through a tag/owner pipeline matched to the multiplier latency. Each product is returned on a shared result bus with a per-requester valid strobe and the requester's tag, so the caller can write it back to the correct RAM address.

---
 rtl/fft_mult_arb_if.sv | 55 +++++
 rtl/fft_mult_arb.sv | 111 +++++++++++
 tb/tb_fft_mult_arb.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_mult_arb_if.sv
// Requester handshakes, multiplier operand/product taps and shared result bus
// for the two-port complex-multiplier arbiter.
interface fft_mult_arb_if #(
  parameter int D_BIT   = 17,
  parameter int W_BIT   = 12,
  parameter int TAG_BIT = 8
);
  logic                    iA_VALID;
  logic                    oA_READY;
  logic signed [D_BIT-1:0] iA_RE;
  logic signed [D_BIT-1:0] iA_IM;
  logic signed [W_BIT-1:0] iA_W_RE;
  logic signed [W_BIT-1:0] iA_W_IM;
  logic [TAG_BIT-1:0]      iA_TAG;

  logic                    iB_VALID;
  logic                    oB_READY;
  logic signed [D_BIT-1:0] iB_RE;
  logic signed [D_BIT-1:0] iB_IM;
  logic signed [W_BIT-1:0] iB_W_RE;
  logic signed [W_BIT-1:0] iB_W_IM;
  logic [TAG_BIT-1:0]      iB_TAG;

  logic signed [D_BIT-1:0] oM_RE;
  logic signed [D_BIT-1:0] oM_IM;
  logic signed [W_BIT-1:0] oM_W_RE;
  logic signed [W_BIT-1:0] oM_W_IM;
  logic signed [D_BIT-1:0] iM_RE;
  logic signed [D_BIT-1:0] iM_IM;

  logic signed [D_BIT-1:0] oRES_RE;
  logic signed [D_BIT-1:0] oRES_IM;
  logic [TAG_BIT-1:0]      oRES_TAG;
  logic                    oA_RES_VALID;
  logic                    oB_RES_VALID;
  logic                    oBUSY;

  modport slave (
    input  iA_VALID, iA_RE, iA_IM, iA_W_RE, iA_W_IM, iA_TAG,
    input  iB_VALID, iB_RE, iB_IM, iB_W_RE, iB_W_IM, iB_TAG,
    input  iM_RE, iM_IM,
    output oA_READY, oB_READY,
    output oM_RE, oM_IM, oM_W_RE, oM_W_IM,
    output oRES_RE, oRES_IM, oRES_TAG, oA_RES_VALID, oB_RES_VALID, oBUSY
  );

  modport master (
    output iA_VALID, iA_RE, iA_IM, iA_W_RE, iA_W_IM, iA_TAG,
    output iB_VALID, iB_RE, iB_IM, iB_W_RE, iB_W_IM, iB_TAG,
    output iM_RE, iM_IM,
    input  oA_READY, oB_READY,
    input  oM_RE, oM_IM, oM_W_RE, oM_W_IM,
    input  oRES_RE, oRES_IM, oRES_TAG, oA_RES_VALID, oB_RES_VALID, oBUSY
  );
endinterface

// File: rtl/fft_mult_arb.sv
// Round-robin arbiter sharing one complex multiplier between two butterfly
// engines; a tag/owner pipeline tracks each product back to its requester.
module fft_mult_arb #(
  parameter int D_BIT   = 17,
  parameter int W_BIT   = 12,
  parameter int TAG_BIT = 8,
  parameter int LAT     = 1
) (
  input logic           iCLK,
  input logic           iRESET,
  fft_mult_arb_if.slave bus
);
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_e;

  req_e prio_q, prio_d;
  logic grant_a, grant_b, xfer;

  logic signed [D_BIT-1:0] m_re_q, m_re_d, m_im_q, m_im_d;
  logic signed [W_BIT-1:0] m_w_re_q, m_w_re_d, m_w_im_q, m_w_im_d;

  // Owner bit per stage: 1 = requester B.
  logic [LAT:0]              vld_q, vld_d;
  logic [LAT:0]              owner_q, owner_d;
  logic [LAT:0][TAG_BIT-1:0] tag_q, tag_d;

  logic signed [D_BIT-1:0] res_re_q, res_re_d, res_im_q, res_im_d;
  logic [TAG_BIT-1:0]      res_tag_q, res_tag_d;
  logic                    res_a_q, res_a_d, res_b_q, res_b_d;

  always_comb begin
    // Ready is held low while reset is asserted so every output reads zero.
    grant_b = iRESET && bus.iB_VALID && (!bus.iA_VALID || prio_q == REQ_B);
    grant_a = iRESET && bus.iA_VALID && !grant_b;
    xfer    = grant_a || grant_b;

    prio_d   = prio_q;
    m_re_d   = m_re_q;
    m_im_d   = m_im_q;
    m_w_re_d = m_w_re_q;
    m_w_im_d = m_w_im_q;
    if (xfer) begin
      prio_d   = grant_b ? REQ_A : REQ_B;
      m_re_d   = grant_b ? bus.iB_RE   : bus.iA_RE;
      m_im_d   = grant_b ? bus.iB_IM   : bus.iA_IM;
      m_w_re_d = grant_b ? bus.iB_W_RE : bus.iA_W_RE;
      m_w_im_d = grant_b ? bus.iB_W_IM : bus.iA_W_IM;
    end

    vld_d   = {vld_q[LAT-1:0], xfer};
    owner_d = {owner_q[LAT-1:0], grant_b};
    tag_d   = {tag_q[LAT-1:0], (grant_b ? bus.iB_TAG : bus.iA_TAG)};

    res_re_d  = res_re_q;
    res_im_d  = res_im_q;
    res_tag_d = res_tag_q;
    res_a_d   = 1'b0;
    res_b_d   = 1'b0;
    if (vld_q[LAT]) begin
      res_re_d  = bus.iM_RE;
      res_im_d  = bus.iM_IM;
      res_tag_d = tag_q[LAT];
      res_a_d   = !owner_q[LAT];
      res_b_d   = owner_q[LAT];
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      prio_q    <= REQ_A;
      m_re_q    <= '0;
      m_im_q    <= '0;
      m_w_re_q  <= '0;
      m_w_im_q  <= '0;
      vld_q     <= '0;
      owner_q   <= '0;
      tag_q     <= '0;
      res_re_q  <= '0;
      res_im_q  <= '0;
      res_tag_q <= '0;
      res_a_q   <= 1'b0;
      res_b_q   <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      m_re_q    <= m_re_d;
      m_im_q    <= m_im_d;
      m_w_re_q  <= m_w_re_d;
      m_w_im_q  <= m_w_im_d;
      vld_q     <= vld_d;
      owner_q   <= owner_d;
      tag_q     <= tag_d;
      res_re_q  <= res_re_d;
      res_im_q  <= res_im_d;
      res_tag_q <= res_tag_d;
      res_a_q   <= res_a_d;
      res_b_q   <= res_b_d;
    end
  end

  assign bus.oA_READY     = grant_a;
  assign bus.oB_READY     = grant_b;
  assign bus.oM_RE        = m_re_q;
  assign bus.oM_IM        = m_im_q;
  assign bus.oM_W_RE      = m_w_re_q;
  assign bus.oM_W_IM      = m_w_im_q;
  assign bus.oRES_RE      = res_re_q;
  assign bus.oRES_IM      = res_im_q;
  assign bus.oRES_TAG     = res_tag_q;
  assign bus.oA_RES_VALID = res_a_q;
  assign bus.oB_RES_VALID = res_b_q;
  assign bus.oBUSY        = (|vld_q) || res_a_q || res_b_q;
endmodule

// File: tb/tb_fft_mult_arb.sv
// Bench for fft_mult_arb: LAT=1 and LAT=3 instances share stimulus and are
// checked against a queue-based transaction model with behavioural multipliers.
module tb_fft_mult_arb;
  localparam int DB = 17;
  localparam int WB = 12;
  localparam int TB = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_mult_arb_if #(.D_BIT(DB), .W_BIT(WB), .TAG_BIT(TB)) b1 ();
  fft_mult_arb_if #(.D_BIT(DB), .W_BIT(WB), .TAG_BIT(TB)) b3 ();

  fft_mult_arb #(.D_BIT(DB), .W_BIT(WB), .TAG_BIT(TB), .LAT(1)) dut1 (
    .iCLK(clk), .iRESET(rst_n), .bus(b1));
  fft_mult_arb #(.D_BIT(DB), .W_BIT(WB), .TAG_BIT(TB), .LAT(3)) dut3 (
    .iCLK(clk), .iRESET(rst_n), .bus(b3));

  assign b3.iA_VALID = b1.iA_VALID;
  assign b3.iA_RE    = b1.iA_RE;
  assign b3.iA_IM    = b1.iA_IM;
  assign b3.iA_W_RE  = b1.iA_W_RE;
  assign b3.iA_W_IM  = b1.iA_W_IM;
  assign b3.iA_TAG   = b1.iA_TAG;
  assign b3.iB_VALID = b1.iB_VALID;
  assign b3.iB_RE    = b1.iB_RE;
  assign b3.iB_IM    = b1.iB_IM;
  assign b3.iB_W_RE  = b1.iB_W_RE;
  assign b3.iB_W_IM  = b1.iB_W_IM;
  assign b3.iB_TAG   = b1.iB_TAG;

  // Complex product scaled so that coefficient 1024 represents 1.0.
  function automatic logic signed [DB-1:0] cre(input logic signed [DB-1:0] ar, ai,
                                                input logic signed [WB-1:0] wr, wi);
    int p;
    p = (int'(ar) * int'(wr) - int'(ai) * int'(wi)) >>> 10;
    return p[DB-1:0];
  endfunction

  function automatic logic signed [DB-1:0] cim(input logic signed [DB-1:0] ar, ai,
                                                input logic signed [WB-1:0] wr, wi);
    int p;
    p = (int'(ar) * int'(wi) + int'(ai) * int'(wr)) >>> 10;
    return p[DB-1:0];
  endfunction

  logic signed [DB-1:0] m1_re, m1_im;
  logic signed [DB-1:0] m3_re [3];
  logic signed [DB-1:0] m3_im [3];
  always_ff @(posedge clk) begin
    m1_re    <= cre(b1.oM_RE, b1.oM_IM, b1.oM_W_RE, b1.oM_W_IM);
    m1_im    <= cim(b1.oM_RE, b1.oM_IM, b1.oM_W_RE, b1.oM_W_IM);
    m3_re[0] <= cre(b3.oM_RE, b3.oM_IM, b3.oM_W_RE, b3.oM_W_IM);
    m3_im[0] <= cim(b3.oM_RE, b3.oM_IM, b3.oM_W_RE, b3.oM_W_IM);
    m3_re[1] <= m3_re[0];
    m3_im[1] <= m3_im[0];
    m3_re[2] <= m3_re[1];
    m3_im[2] <= m3_im[1];
  end
  assign b1.iM_RE = m1_re;
  assign b1.iM_IM = m1_im;
  assign b3.iM_RE = m3_re[2];
  assign b3.iM_IM = m3_im[2];

  typedef struct {
    logic                 v;
    logic signed [DB-1:0] re, im;
    logic signed [WB-1:0] wr, wi;
    logic [TB-1:0]        tag;
  } op_t;

  typedef struct {
    logic                 own_b;
    logic [TB-1:0]        tag;
    logic signed [DB-1:0] re, im;
    int                   due;
  } exp_t;

  typedef struct {
    logic av, bv, ra, rb;
  } vec_t;

  exp_t q1[$];
  exp_t q3[$];
  int   tests = 0;
  int   fails = 0;
  int   edges = 0;
  logic pref_b = 1'b0;
  logic act_ra, act_rb;
  int   a_cnt, b_cnt, l3_edge;
  logic [TB-1:0] seen_a[$];
  logic signed [DB-1:0] last_a_re, last_a_im, last_b_re, last_b_im;

  task automatic expect_eq(input string name, input logic signed [63:0] act,
                           input logic signed [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic op_t rnd_op(input int pct);
    op_t o;
    o.v   = ($urandom_range(99) < pct);
    o.re  = DB'($urandom);
    o.im  = DB'($urandom);
    o.wr  = WB'($urandom);
    o.wi  = WB'($urandom);
    o.tag = TB'($urandom);
    return o;
  endfunction

  task automatic chk(input int lat, input logic sa, sb, input logic signed [DB-1:0] re, im,
                     input logic [TB-1:0] tag, input logic busy);
    exp_t  e;
    logic  hit;
    int    left;
    string s;
    hit = 1'b0;
    e   = '{default: '0};
    if (lat == 1) begin
      if (q1.size() != 0 && q1[0].due == edges) begin e = q1.pop_front(); hit = 1'b1; end
      left = q1.size();
    end else begin
      if (q3.size() != 0 && q3[0].due == edges) begin e = q3.pop_front(); hit = 1'b1; end
      left = q3.size();
    end
    s = (lat == 1) ? "L1" : "L3";
    expect_eq({"A_RES_VALID_", s}, sa, hit && !e.own_b);
    expect_eq({"B_RES_VALID_", s}, sb, hit && e.own_b);
    if (hit) begin
      expect_eq({"RES_TAG_", s}, tag, e.tag);
      expect_eq({"RES_RE_", s}, re, e.re);
      expect_eq({"RES_IM_", s}, im, e.im);
    end
    expect_eq({"BUSY_", s}, busy, hit || left != 0);
  endtask

  // One clock: drive at the falling edge, check ready, model the transfer,
  // then check registered outputs at the next falling edge.
  task automatic apply(input op_t a, input op_t b);
    logic ga, gb;
    exp_t e;
    op_t  sel;
    b1.iA_VALID = a.v; b1.iA_RE = a.re; b1.iA_IM = a.im;
    b1.iA_W_RE = a.wr; b1.iA_W_IM = a.wi; b1.iA_TAG = a.tag;
    b1.iB_VALID = b.v; b1.iB_RE = b.re; b1.iB_IM = b.im;
    b1.iB_W_RE = b.wr; b1.iB_W_IM = b.wi; b1.iB_TAG = b.tag;
    #1;
    ga = 1'b0;
    gb = 1'b0;
    if (rst_n) begin
      if (a.v && b.v) begin
        if (pref_b) gb = 1'b1; else ga = 1'b1;
      end else if (a.v) ga = 1'b1;
      else if (b.v) gb = 1'b1;
    end else begin
      q1.delete();
      q3.delete();
      pref_b = 1'b0;
    end
    act_ra = b1.oA_READY;
    act_rb = b1.oB_READY;
    expect_eq("A_READY_L1", b1.oA_READY, ga);
    expect_eq("B_READY_L1", b1.oB_READY, gb);
    expect_eq("A_READY_L3", b3.oA_READY, ga);
    expect_eq("B_READY_L3", b3.oB_READY, gb);
    if (ga || gb) begin
      sel     = gb ? b : a;
      e.own_b = gb;
      e.tag   = sel.tag;
      e.re    = cre(sel.re, sel.im, sel.wr, sel.wi);
      e.im    = cim(sel.re, sel.im, sel.wr, sel.wi);
      e.due   = edges + 1 + 1 + 1;
      q1.push_back(e);
      e.due   = edges + 1 + 3 + 1;
      q3.push_back(e);
      pref_b  = ga;
    end
    @(posedge clk);
    edges++;
    @(negedge clk);
    chk(1, b1.oA_RES_VALID, b1.oB_RES_VALID, b1.oRES_RE, b1.oRES_IM, b1.oRES_TAG, b1.oBUSY);
    chk(3, b3.oA_RES_VALID, b3.oB_RES_VALID, b3.oRES_RE, b3.oRES_IM, b3.oRES_TAG, b3.oBUSY);
    if (b1.oA_RES_VALID) begin
      a_cnt++;
      seen_a.push_back(b1.oRES_TAG);
      last_a_re = b1.oRES_RE;
      last_a_im = b1.oRES_IM;
    end
    if (b1.oB_RES_VALID) begin
      b_cnt++;
      last_b_re = b1.oRES_RE;
      last_b_im = b1.oRES_IM;
    end
    if (b3.oB_RES_VALID) l3_edge = edges;
  endtask

  initial begin
    op_t  a, b, idle;
    vec_t tbl[10];
    int   acc_edge;
    logic [TB-1:0] at, bt;
    idle = '{default: '0};
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      apply(rnd_op(100), rnd_op(100));
      expect_eq("RESET_OUTS_L1", |{b1.oA_READY, b1.oB_READY, b1.oM_RE, b1.oM_IM, b1.oM_W_RE,
        b1.oM_W_IM, b1.oRES_RE, b1.oRES_IM, b1.oRES_TAG, b1.oA_RES_VALID, b1.oB_RES_VALID}, 0);
      expect_eq("RESET_OUTS_L3", |{b3.oA_READY, b3.oB_READY, b3.oM_RE, b3.oM_IM, b3.oM_W_RE,
        b3.oM_W_IM, b3.oRES_RE, b3.oRES_IM, b3.oRES_TAG, b3.oA_RES_VALID, b3.oB_RES_VALID}, 0);
      expect_eq("RESET_BUSY", b1.oBUSY || b3.oBUSY, 0);
    end
    rst_n = 1'b1;

    // Grant table starting from the post-reset priority.
    for (int i = 0; i < 10; i++) begin
      a = rnd_op(0); a.v = tbl[i].av; a.tag = TB'(i);
      b = rnd_op(0); b.v = tbl[i].bv; b.tag = TB'(8'h40 + i);
      apply(a, b);
      expect_eq("TBL_A_READY", act_ra, tbl[i].ra);
      expect_eq("TBL_B_READY", act_rb, tbl[i].rb);
    end
    repeat (6) apply(idle, idle);

    a_cnt = 0; b_cnt = 0; seen_a.delete();
    for (int i = 0; i < 4; i++) begin
      a = rnd_op(100); a.tag = TB'(i);
      apply(a, idle);
      expect_eq("AONLY_READY", act_ra, 1);
    end
    repeat (6) apply(idle, idle);
    expect_eq("AONLY_A_COUNT", a_cnt, 4);
    expect_eq("AONLY_B_COUNT", b_cnt, 0);
    for (int k = 0; k < 4; k++)
      expect_eq("AONLY_TAG", (k < seen_a.size()) ? seen_a[k] : 8'hFF, k);

    // Single B op moves priority back to A ahead of the contention run.
    b = rnd_op(100);
    apply(idle, b);
    at = 8'h10; bt = 8'h20;
    for (int i = 0; i < 8; i++) begin
      a = rnd_op(100); a.tag = at;
      b = rnd_op(100); b.tag = bt;
      apply(a, b);
      expect_eq("CONT_A_READY", act_ra, (i % 2) == 0);
      expect_eq("CONT_B_READY", act_rb, (i % 2) == 1);
      if (act_ra) at++;
      if (act_rb) bt++;
    end
    repeat (6) apply(idle, idle);

    a = '{1'b1, 17'sd32767, 17'sd0, 12'sd0, 12'sd1023, 8'h31};
    b = '{1'b1, 17'sd0, 17'sd32767, 12'sd1023, 12'sd0, 8'h32};
    apply(a, b);
    apply(idle, b);
    repeat (6) apply(idle, idle);
    expect_eq("DP_A_RE", last_a_re, 0);
    expect_eq("DP_A_IM", last_a_im, 32735);
    expect_eq("DP_B_RE", last_b_re, 0);
    expect_eq("DP_B_IM", last_b_im, 32735);
    expect_eq("DP_A_ANGLE90", last_a_im > 0 &&
      ((last_a_re < 0) ? -int'(last_a_re) : int'(last_a_re)) * 57 <= int'(last_a_im), 1);
    expect_eq("DP_B_ANGLE90", last_b_im > 0 &&
      ((last_b_re < 0) ? -int'(last_b_re) : int'(last_b_re)) * 57 <= int'(last_b_im), 1);

    // Reset one cycle after accepting tag 5 must discard it.
    a_cnt = 0;
    a = rnd_op(100); a.tag = 8'h05;
    apply(a, idle);
    rst_n = 1'b0;
    apply(idle, idle);
    rst_n = 1'b1;
    repeat (6) apply(idle, idle);
    expect_eq("MID_NO_STROBE", a_cnt, 0);
    expect_eq("MID_BUSY_L1", b1.oBUSY, 0);
    expect_eq("MID_BUSY_L3", b3.oBUSY, 0);
    apply(rnd_op(100), rnd_op(100));
    expect_eq("MID_PRIO_A", act_ra, 1);
    repeat (6) apply(idle, idle);

    l3_edge = -1;
    b = rnd_op(100); b.tag = 8'h07;
    acc_edge = edges + 1;
    apply(idle, b);
    repeat (6) apply(idle, idle);
    expect_eq("L3_LATENCY", l3_edge - acc_edge, 4);

    for (int i = 0; i < 400; i++) apply(rnd_op(60), rnd_op(60));
    repeat (6) apply(idle, idle);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
